npu_layer_sequencer: RTL and testbench

//  Sequences math_calculation_core through one full neural-network layer per configuration.

---
 rtl/npu_layer_sequencer_pkg.sv | 20 ++
 rtl/npu_layer_sequencer_watchdog.sv | 31 +++
 rtl/npu_layer_sequencer.sv | 148 ++++++++++++++
 tb/tb_npu_layer_sequencer.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/npu_layer_sequencer_pkg.sv
// Shared constants and state encoding for the NPU layer sequencer and its watchdog.
package npu_layer_sequencer_pkg;

    localparam int NPU_DATA_WIDTH = 16;
    localparam int ADDR_W         = 8;
    localparam int CNT_W          = 8;
    localparam int TIMEOUT        = 255;

    typedef enum logic [2:0] {
        SEQ_IDLE,
        SEQ_FETCH,
        SEQ_MAC_ISSUE,
        SEQ_MAC_WAIT,
        SEQ_ACT_ISSUE,
        SEQ_ACT_WAIT,
        SEQ_WRITE,
        SEQ_DONE
    } seq_state_t;

endpackage

// File: rtl/npu_layer_sequencer_watchdog.sv
// npu_seq_watchdog: counts cycles spent waiting on the math core and flags expiry.
// The count clears whenever i_run is low, so every wait state starts from zero.
module npu_seq_watchdog
    import npu_layer_sequencer_pkg::*;
#(
    parameter int LIMIT = TIMEOUT
) (
    input  logic clk,
    input  logic rst,
    input  logic i_run,
    output logic o_expire
);

    localparam int CW = $clog2(LIMIT + 1);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_run) begin
            r_cnt <= r_cnt + CW'(1);
        end else begin
            r_cnt <= '0;
        end
    end

    // Expiry on the last waiting cycle lands the error pulse LIMIT cycles after entry.
    assign o_expire = i_run && (r_cnt == CW'(LIMIT - 1));

endmodule

// File: rtl/npu_layer_sequencer.sv
// npu_layer_sequencer: steps one NN layer (neuron outer loop, input inner loop) through the math core.
// Optional busy-cycle counter output perf_cycles is built when LAYER_PERF_CNT_EN is defined.
// Config handshake: transfer on cfg_valid & cfg_ready; cfg_ready is high only while IDLE.
module npu_layer_sequencer
    import npu_layer_sequencer_pkg::*;
(
    input  logic              clk,
    input  logic              reset_b,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [CNT_W-1:0]  cfg_num_inputs,
    input  logic [CNT_W-1:0]  cfg_num_neurons,
    input  logic [ADDR_W-1:0] cfg_in_base,
    input  logic [ADDR_W-1:0] cfg_w_base,
    input  logic [ADDR_W-1:0] cfg_out_base,
    input  logic              abort,
    output logic              rd_en,
    output logic [ADDR_W-1:0] in_addr,
    output logic [ADDR_W-1:0] w_addr,
    output logic              calc_start,
    input  logic              calc_valid,
    output logic              sig_start,
    input  logic              sig_valid,
    output logic              res_we,
    output logic [ADDR_W-1:0] res_addr,
    output logic              busy,
    output logic              layer_done,
    output logic              err,
`ifdef LAYER_PERF_CNT_EN
    output logic [31:0]       perf_cycles,
`endif
    output seq_state_t        dbg_state
);

    seq_state_t        r_state, w_next;
    logic [CNT_W-1:0]  r_num_in, r_num_neu, r_i, r_n;
    logic [ADDR_W-1:0] r_in_base, r_out_base, r_wptr;
    logic              r_err, r_bad_done;
    logic              w_hs, w_bad, w_wait, w_expire, w_timeout, w_mac_last, w_neu_last;

    assign w_hs       = (r_state == SEQ_IDLE) && cfg_valid && !abort;
    assign w_bad      = (cfg_num_inputs == '0) || (cfg_num_neurons == '0);
    assign w_wait     = (r_state == SEQ_MAC_WAIT) || (r_state == SEQ_ACT_WAIT);
    assign w_mac_last = (r_i == r_num_in - CNT_W'(1));
    assign w_neu_last = (r_n == r_num_neu - CNT_W'(1));
    // A valid arriving on the final watchdog cycle still counts as a response.
    assign w_timeout  = w_expire && !abort &&
                        (((r_state == SEQ_MAC_WAIT) && !calc_valid) ||
                         ((r_state == SEQ_ACT_WAIT) && !sig_valid));

    npu_seq_watchdog #(.LIMIT(TIMEOUT)) u_watchdog (
        .clk      (clk),
        .rst      (reset_b),
        .i_run    (w_wait),
        .o_expire (w_expire)
    );

    always_ff @(posedge clk or posedge reset_b) begin
        if (reset_b) begin
            r_state    <= SEQ_IDLE;
            r_num_in   <= '0;
            r_num_neu  <= '0;
            r_i        <= '0;
            r_n        <= '0;
            r_in_base  <= '0;
            r_out_base <= '0;
            r_wptr     <= '0;
            r_err      <= 1'b0;
            r_bad_done <= 1'b0;
        end else begin
            r_state    <= w_next;
            r_err      <= (w_hs && w_bad) || w_timeout;
            r_bad_done <= w_hs && w_bad;
            if (w_hs) begin
                r_num_in   <= cfg_num_inputs;
                r_num_neu  <= cfg_num_neurons;
                r_in_base  <= cfg_in_base;
                r_out_base <= cfg_out_base;
                r_wptr     <= cfg_w_base;
                r_i        <= '0;
                r_n        <= '0;
            end else if (!abort) begin
                if ((r_state == SEQ_MAC_WAIT) && calc_valid) begin
                    r_i    <= r_i + CNT_W'(1);
                    r_wptr <= r_wptr + ADDR_W'(1);
                end
                // Weight pointer keeps running across neurons: rows are contiguous.
                if (r_state == SEQ_WRITE) begin
                    r_i <= '0;
                    r_n <= r_n + CNT_W'(1);
                end
            end
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            SEQ_IDLE:      if (w_hs && !w_bad) w_next = SEQ_FETCH;
            SEQ_FETCH:     w_next = SEQ_MAC_ISSUE;
            SEQ_MAC_ISSUE: w_next = SEQ_MAC_WAIT;
            SEQ_MAC_WAIT: begin
                if (calc_valid)    w_next = w_mac_last ? SEQ_ACT_ISSUE : SEQ_FETCH;
                else if (w_expire) w_next = SEQ_IDLE;
            end
            SEQ_ACT_ISSUE: w_next = SEQ_ACT_WAIT;
            SEQ_ACT_WAIT: begin
                if (sig_valid)     w_next = SEQ_WRITE;
                else if (w_expire) w_next = SEQ_IDLE;
            end
            SEQ_WRITE:     w_next = w_neu_last ? SEQ_DONE : SEQ_FETCH;
            SEQ_DONE:      w_next = SEQ_IDLE;
            default:       w_next = SEQ_IDLE;
        endcase
        if (abort) w_next = SEQ_IDLE;
    end

    // Abort silences every strobe in the cycle it is seen.
    assign cfg_ready  = (r_state == SEQ_IDLE);
    assign busy       = (r_state != SEQ_IDLE);
    assign rd_en      = (r_state == SEQ_FETCH) && !abort;
    assign calc_start = (r_state == SEQ_MAC_ISSUE) && !abort;
    assign sig_start  = (r_state == SEQ_ACT_ISSUE) && !abort;
    assign res_we     = (r_state == SEQ_WRITE) && !abort;
    assign layer_done = ((r_state == SEQ_DONE) || r_bad_done) && !abort;
    assign err        = r_err && !abort;
    assign in_addr    = r_in_base + ADDR_W'(r_i);
    assign w_addr     = r_wptr;
    assign res_addr   = r_out_base + ADDR_W'(r_n);
    assign dbg_state  = r_state;

`ifdef LAYER_PERF_CNT_EN
    logic [31:0] r_perf;

    always_ff @(posedge clk or posedge reset_b) begin
        if (reset_b) begin
            r_perf <= '0;
        end else if (w_hs) begin
            r_perf <= '0;
        end else if (busy && (r_perf != '1)) begin
            r_perf <= r_perf + 32'd1;
        end
    end

    assign perf_cycles = r_perf;
`endif

endmodule

// File: tb/tb_npu_layer_sequencer.sv
// Randomized scoreboard bench for npu_layer_sequencer; perf_cycles is checked when LAYER_PERF_CNT_EN is defined.
module tb_npu_layer_sequencer;
  import npu_layer_sequencer_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset_b;
  always #5 clk = ~clk;

  logic       cfg_valid, cfg_ready, abort;
  logic [7:0] cfg_num_inputs, cfg_num_neurons, cfg_in_base, cfg_w_base, cfg_out_base;
  logic       rd_en, calc_start, sig_start, res_we, busy, layer_done, err;
  logic [7:0] in_addr, w_addr, res_addr;
  logic       cv_resp, cv_drv, sv_resp;
  logic       calc_valid, sig_valid;
  seq_state_t dbg_state;
`ifdef LAYER_PERF_CNT_EN
  logic [31:0] perf_cycles;
`endif

  assign calc_valid = cv_resp | cv_drv;
  assign sig_valid  = sv_resp;

  npu_layer_sequencer dut (
    .clk(clk), .reset_b(reset_b), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_num_inputs(cfg_num_inputs), .cfg_num_neurons(cfg_num_neurons),
    .cfg_in_base(cfg_in_base), .cfg_w_base(cfg_w_base), .cfg_out_base(cfg_out_base),
    .abort(abort), .rd_en(rd_en), .in_addr(in_addr), .w_addr(w_addr),
    .calc_start(calc_start), .calc_valid(calc_valid), .sig_start(sig_start),
    .sig_valid(sig_valid), .res_we(res_we), .res_addr(res_addr), .busy(busy),
    .layer_done(layer_done), .err(err),
`ifdef LAYER_PERF_CNT_EN
    .perf_cycles(perf_cycles),
`endif
    .dbg_state(dbg_state)
  );

  // ---------------- scoreboard ----------------
  logic [15:0] exp_rd_q[$];   // {in_addr, w_addr}
  logic [7:0]  exp_wr_q[$];   // res_addr
  logic [1:0]  exp_end_q[$];  // {layer_done, err}
  int n_cmp = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: every neuron reads N inputs and the next N weights of a contiguous
  // row-major matrix. stop_n/stop_i >= 0 truncates the layer at an abort/timeout point.
  task automatic push_model(input int n_in, input int n_neu, input int in_b, input int w_b,
                            input int out_b, input int stop_n, input int stop_i);
    for (int n = 0; n < n_neu; n++) begin
      for (int i = 0; i < n_in; i++) begin
        if (stop_n < 0 || n < stop_n || (n == stop_n && i <= stop_i))
          exp_rd_q.push_back({8'(in_b + i), 8'(w_b + n * n_in + i)});
      end
      if (stop_n < 0 || n < stop_n) exp_wr_q.push_back(8'(out_b + n));
    end
    if (stop_n < 0) exp_end_q.push_back(2'b10);
  endtask

  // ---------------- core responder ----------------
  int calc_cnt = 0, sig_cnt = 0, calc_budget = -1;
  int d_min = 4, d_max = 4;
  bit resp_en = 1'b1, stray_en = 1'b0;

  initial begin
    cv_resp = 1'b0;
    sv_resp = 1'b0;
    forever begin
      @(negedge clk);
      #1;
      cv_resp = 1'b0;
      sv_resp = 1'b0;
      if (reset_b) begin
        calc_cnt = 0;
        sig_cnt  = 0;
      end else begin
        if (calc_cnt > 0) begin
          calc_cnt--;
          if (calc_cnt == 0) cv_resp = 1'b1;
          else if (stray_en && $urandom_range(0, 3) == 0) sv_resp = 1'b1;
        end else if (calc_start && resp_en && calc_budget != 0) begin
          calc_cnt = $urandom_range(d_min, d_max);
          if (calc_budget > 0) calc_budget--;
        end
        if (sig_cnt > 0) begin
          sig_cnt--;
          if (sig_cnt == 0) sv_resp = 1'b1;
          else if (stray_en && $urandom_range(0, 3) == 0) cv_resp = 1'b1;
        end else if (sig_start && resp_en) begin
          sig_cnt = $urandom_range(d_min, d_max);
        end
      end
    end
  end

  // ---------------- monitor ----------------
  int cyc = 0, busy_cnt = 0, n_calc = 0, n_sig = 0;
  int last_calc_cyc = 0, end_cyc = 0;
  logic end_busy = 1'b0;

  initial begin
    forever begin
      @(negedge clk);
      #2;
      cyc++;
      if (busy) busy_cnt++;
      if (calc_start) begin n_calc++; last_calc_cyc = cyc; end
      if (sig_start) n_sig++;
      if (rd_en) begin
        if (exp_rd_q.size() == 0) begin
          n_cmp++; n_fail++;
          $display("FAIL rd_unexpected: in_addr 0x%0h w_addr 0x%0h, no read expected", in_addr, w_addr);
        end else check("rd_addr", {in_addr, w_addr}, exp_rd_q.pop_front());
      end
      if (res_we) begin
        if (exp_wr_q.size() == 0) begin
          n_cmp++; n_fail++;
          $display("FAIL wr_unexpected: res_addr 0x%0h, no write expected", res_addr);
        end else check("res_addr", res_addr, exp_wr_q.pop_front());
      end
      if (layer_done || err) begin
        end_cyc  = cyc;
        end_busy = busy;
        if (exp_end_q.size() == 0) begin
          n_cmp++; n_fail++;
          $display("FAIL end_unexpected: layer_done %0b err %0b, none expected", layer_done, err);
        end else check("end_evt", {layer_done, err}, exp_end_q.pop_front());
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic check_quiet(input string tag);
    check({tag, "_cfg_ready"}, cfg_ready, 1);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_strobes"}, {rd_en, calc_start, sig_start, res_we, layer_done, err}, 0);
    check({tag, "_addrs"}, {in_addr, w_addr, res_addr}, 0);
  endtask

  task automatic send_cfg(input int n_in, input int n_neu, input int in_b, input int w_b, input int out_b);
    int k;
    k = 0;
    @(negedge clk);
    while (!cfg_ready && k < 100) begin @(negedge clk); k++; end
    check("cfg_ready_wait", cfg_ready, 1);
    cfg_valid       = 1'b1;
    cfg_num_inputs  = 8'(n_in);
    cfg_num_neurons = 8'(n_neu);
    cfg_in_base     = 8'(in_b);
    cfg_w_base      = 8'(w_b);
    cfg_out_base    = 8'(out_b);
    busy_cnt        = 0;
    @(negedge clk);
    cfg_valid       = 1'b0;
    cfg_num_inputs  = $urandom_range(0, 255);
    cfg_w_base      = $urandom_range(0, 255);
  endtask

  task automatic wait_drain(input string tag, input int budget);
    int k;
    k = 0;
    while ((exp_rd_q.size() + exp_wr_q.size() + exp_end_q.size()) != 0 && k < budget) begin
      @(negedge clk);
      k++;
    end
    check({tag, "_drain"}, exp_rd_q.size() + exp_wr_q.size() + exp_end_q.size(), 0);
    @(negedge clk);
    #3;
    check({tag, "_idle"}, cfg_ready, 1);
  endtask

  task automatic run_layer(input string tag, input int n_in, input int n_neu,
                           input int in_b, input int w_b, input int out_b);
    int c0, s0;
    c0 = n_calc;
    s0 = n_sig;
    push_model(n_in, n_neu, in_b, w_b, out_b, -1, -1);
    send_cfg(n_in, n_neu, in_b, w_b, out_b);
    wait_drain(tag, 3000);
    check({tag, "_calc_cnt"}, n_calc - c0, n_in * n_neu);
    check({tag, "_sig_cnt"}, n_sig - s0, n_neu);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "global timeout");
  end

  // ---------------- main sequence ----------------
  initial begin
    int k, c0;
    reset_b = 1'b0;
    cfg_valid = 1'b0; abort = 1'b0; cv_drv = 1'b0;
    cfg_num_inputs = '0; cfg_num_neurons = '0;
    cfg_in_base = '0; cfg_w_base = '0; cfg_out_base = '0;
    #1 reset_b = 1'b1;
    #1 check_quiet("reset");
    repeat (2) @(negedge clk);
    reset_b = 1'b0;

    // Nominal layer, fixed 4-cycle core latency: 6 inputs x 6 cycles + 2 x (act 5 + write 1) + done.
    run_layer("nominal", 3, 2, 'h10, 'h40, 'h80);
    check("nominal_busy_cycles", busy_cnt, 49);
`ifdef LAYER_PERF_CNT_EN
    check("nominal_perf_cycles", perf_cycles, 49);
`endif

    // Empty layers: error and done together, one cycle after handshake.
    exp_end_q.push_back(2'b11);
    send_cfg(0, 5, 'h10, 'h40, 'h80);
    #3;
    check("bad_n_pulse", {err, layer_done, cfg_ready}, 3'b111);
    @(negedge clk); #3;
    check("bad_n_single", {err, layer_done}, 2'b00);
    exp_end_q.push_back(2'b11);
    send_cfg(3, 0, 'h10, 'h40, 'h80);
    wait_drain("bad_m", 10);

    // Weight pointer wraps through 0xFF.
    run_layer("wrap", 4, 1, 'h20, 'hFE, 'h90);

    // Abort in MAC_WAIT of neuron 1 input 2, together with a calc_valid.
    c0 = n_calc;
    calc_budget = 5;
    push_model(3, 2, 'h10, 'h40, 'h80, 1, 2);
    send_cfg(3, 2, 'h10, 'h40, 'h80);
    k = 0;
    while (n_calc - c0 < 6 && k < 500) begin @(negedge clk); #3; k++; end
    check("abort_reach", n_calc - c0, 6);
    @(negedge clk);
    abort = 1'b1;
    cv_drv = 1'b1;
    #3 check("abort_strobes", {rd_en, calc_start, sig_start, res_we, layer_done, err}, 0);
    @(negedge clk);
    abort = 1'b0;
    cv_drv = 1'b0;
    #3 check("abort_idle", {busy, cfg_ready}, 2'b01);
    calc_budget = -1;
    wait_drain("abort", 20);
    run_layer("after_abort", 2, 2, 'h00, 'h10, 'h20);

    // Core never answers: error exactly TIMEOUT cycles after entering MAC_WAIT.
    resp_en = 1'b0;
    push_model(2, 1, 'h30, 'h50, 'h70, 0, 0);
    exp_end_q.push_back(2'b01);
    send_cfg(2, 1, 'h30, 'h50, 'h70);
    wait_drain("timeout", 600);
    check("timeout_latency", end_cyc - last_calc_cyc, TIMEOUT + 1);
    check("timeout_busy", end_busy, 0);
    resp_en = 1'b1;

    // Randomized layers with variable latency and stray valids.
    stray_en = 1'b1;
    d_min = 1;
    d_max = 6;
    for (int t = 0; t < 8; t++)
      run_layer("random", $urandom_range(1, 4), $urandom_range(1, 3),
                $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255));
    stray_en = 1'b0;

    // Asynchronous reset in the middle of a layer.
    push_model(3, 2, 'h10, 'h40, 'h80, -1, -1);
    send_cfg(3, 2, 'h10, 'h40, 'h80);
    repeat (7) @(negedge clk);
    #3 reset_b = 1'b1;
    #1 check_quiet("mid_reset");
    exp_rd_q.delete();
    exp_wr_q.delete();
    exp_end_q.delete();
    repeat (2) @(negedge clk);
    reset_b = 1'b0;
    run_layer("after_reset", 2, 3, 'hF0, 'hFA, 'hFE);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
